axi_al_rd_burst: RTL and testbench

Bridges AXI4 INCR read bursts onto the single-beat address/data read bus (`m_al_ar*` / `m_al_r*`) consumed by the readback mux. It sits directly upstream of the read mux. It splits each burst into `arlen+1` word reads, bounds the number of in-flight reads, and reassembles the returned words into an AXI R stream with `rid` and `rlast`.

---
 rtl/axi_al_rd_burst.sv | 120 ++++++++++++
 tb/tb_axi_al_rd_burst.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_al_rd_burst.sv
// rtl/axi_al_rd_burst.sv - AXI4 INCR read burst to single-beat AL read bridge
module axi_al_rd_burst #(
  parameter int DATA_BITS       = 2,
  parameter int DATA_WIDTH      = 8 << DATA_BITS,
  parameter int ADDR_WIDTH      = 16,
  parameter int ID_WIDTH        = 1,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
  input  logic [LEN_WIDTH-1:0]            s_axi_arlen,
  input  logic [ID_WIDTH-1:0]             s_axi_arid,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [DATA_WIDTH-1:0]           s_axi_rdata,
  output logic [ID_WIDTH-1:0]             s_axi_rid,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [ADDR_WIDTH-1:DATA_BITS]   m_al_araddr,
  output logic [ID_WIDTH-1:0]             m_al_arid,
  output logic                            m_al_arvalid,
  input  logic                            m_al_arready,
  input  logic [DATA_WIDTH-1:0]           m_al_rdata,
  input  logic [ID_WIDTH-1:0]             m_al_rid,
  input  logic                            m_al_rvalid,
  output logic                            m_al_rready
);

  localparam int WA = ADDR_WIDTH - DATA_BITS;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state, state_nx;
  logic [WA-1:0]        waddr;
  logic [LEN_WIDTH-1:0] len, icnt, rcnt;
  logic [ID_WIDTH-1:0]  id;
  logic [OW-1:0]        outstanding, outstanding_nx;
  logic                 arvalid_q;
  logic                 ar_hs, al_ar_hs, r_hs;
  logic                 unused_low_addr;

  assign unused_low_addr = ^s_axi_araddr[DATA_BITS-1:0];

  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign al_ar_hs = arvalid_q && m_al_arready;
  // Returns only count against a live burst; nothing is in flight while idle.
  assign r_hs     = m_al_rvalid && s_axi_rready && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ar_hs) state_nx = ISSUE;
      ISSUE:   if (al_ar_hs && icnt == len) state_nx = DRAIN;
      DRAIN:   if (r_hs && rcnt == len) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (state == IDLE);
    s_axi_rlast   = (state != IDLE) && (rcnt == len);
    s_axi_rvalid  = m_al_rvalid;
    s_axi_rdata   = m_al_rdata;
    s_axi_rid     = m_al_rid;
    s_axi_rresp   = 2'b00;
    m_al_rready   = s_axi_rready;
    m_al_araddr   = waddr;
    m_al_arid     = id;
    m_al_arvalid  = arvalid_q;
  end

  always_comb begin
    outstanding_nx = outstanding;
    if (al_ar_hs && !r_hs)
      outstanding_nx = outstanding + OW'(1);
    else if (r_hs && !al_ar_hs && outstanding != '0)
      outstanding_nx = outstanding - OW'(1);
  end

  // arvalid is precomputed from next-cycle state so the AL request is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr       <= '0;
      len         <= '0;
      id          <= '0;
      icnt        <= '0;
      rcnt        <= '0;
      outstanding <= '0;
      arvalid_q   <= 1'b0;
    end else begin
      if (ar_hs) begin
        waddr <= s_axi_araddr[ADDR_WIDTH-1:DATA_BITS];
        len   <= s_axi_arlen;
        id    <= s_axi_arid;
        icnt  <= '0;
        rcnt  <= '0;
      end else begin
        if (al_ar_hs) begin
          waddr <= waddr + WA'(1);
          icnt  <= icnt + LEN_WIDTH'(1);
        end
        if (r_hs) rcnt <= rcnt + LEN_WIDTH'(1);
      end
      outstanding <= outstanding_nx;
      arvalid_q   <= (state_nx == ISSUE) && (outstanding_nx != MAX_OS);
    end
  end

endmodule

// File: tb/tb_axi_al_rd_burst.sv
// tb/tb_axi_al_rd_burst.sv - self-checking bench for axi_al_rd_burst
module tb_axi_al_rd_burst;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_arid;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rid;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [15:2] m_al_araddr;
  logic        m_al_arid;
  logic        m_al_arvalid;
  logic        m_al_arready = 1'b1;
  logic [31:0] m_al_rdata = '0;
  logic        m_al_rid = 1'b0;
  logic        m_al_rvalid = 1'b0;
  logic        m_al_rready;

  always #5 clk = ~clk;

  axi_al_rd_burst #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arid(s_axi_arid),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_al_araddr(m_al_araddr), .m_al_arid(m_al_arid), .m_al_arvalid(m_al_arvalid),
    .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rid(m_al_rid),
    .m_al_rvalid(m_al_rvalid), .m_al_rready(m_al_rready)
  );

  // Word-addressed memory behind the mux; words 0x100..0x10F are unmapped.
  logic [31:0] mem [0:16383];
  function automatic logic [31:0] rd_word(input logic [13:0] w);
    return (w >= 14'h100 && w < 14'h110) ? 32'hffffffff : mem[w];
  endfunction

  typedef struct {
    logic [15:0] addr;
    int          len;
    logic        id;
    int          rmode;
    int          amode;
    int          hold;
    logic [13:0] exp_first;
    logic [13:0] exp_last;
  } vec_t;

  typedef struct packed { logic [31:0] d; logic id; logic last; } beat_t;
  typedef struct packed { logic [13:0] a; logic id; } req_t;

  logic [13:0] exp_a [$];
  beat_t       exp_b [$];
  req_t        rq    [$];

  int errors = 0, checks = 0;
  int issued = 0, returned = 0, cyc = 0, first_c = 0, last_c = 0;
  int rmode = 0, amode = 0, hold = 0;
  logic [13:0] first_a, last_a, st_addr;
  logic [31:0] st_d;
  logic cur_id = 1'b0;
  bit arr_chk = 0, st_r = 0, st_a = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every AL issue and every R beat against the model queues.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      beat_t b;
      if (arr_chk) begin chk("arready_after_last", s_axi_arready, 1); arr_chk = 0; end
      if (st_r) begin
        chk("r_stall_valid", s_axi_rvalid, 1);
        chk("r_stall_data", s_axi_rdata, st_d);
      end
      if (st_a) begin
        chk("ar_stall_valid", m_al_arvalid, 1);
        chk("ar_stall_addr", m_al_araddr, st_addr);
      end
      st_r = s_axi_rvalid && !s_axi_rready; st_d = s_axi_rdata;
      st_a = m_al_arvalid && !m_al_arready; st_addr = m_al_araddr;
      if (m_al_arvalid && m_al_arready) begin
        chk("credit", (issued - returned) < MAXO, 1);
        if (exp_a.size() == 0) chk("unexpected_ar", 1, 0);
        else chk("al_addr", m_al_araddr, exp_a.pop_front());
        chk("al_id", m_al_arid, cur_id);
        if (issued == 0) begin first_a = m_al_araddr; first_c = cyc; end
        last_a = m_al_araddr; last_c = cyc;
        issued++;
        rq.push_back({m_al_araddr, m_al_arid});
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_b.size() == 0) chk("unexpected_r", 1, 0);
        else begin
          b = exp_b.pop_front();
          chk("rdata", s_axi_rdata, b.d);
          chk("rid", s_axi_rid, b.id);
          chk("rlast", s_axi_rlast, b.last);
          chk("rresp", s_axi_rresp, 0);
          if (b.last) arr_chk = 1;
        end
        returned++;
        if (rq.size() > 0) void'(rq.pop_front());
      end
    end
  end

  // Downstream mux model: answers queued reads in order, one cycle after issue at the earliest.
  always @(posedge clk) begin
    #1;
    if (hold > 0) hold--;
    s_axi_rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~s_axi_rready : 1'($urandom_range(0, 1));
    m_al_arready = (amode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rq.size() > 0 && hold == 0) begin
      m_al_rvalid = 1'b1;
      m_al_rdata  = rd_word(rq[0].a);
      m_al_rid    = rq[0].id;
    end else begin
      m_al_rvalid = 1'b0;
      m_al_rdata  = 32'h0;
    end
  end

  task automatic start_burst(input logic [15:0] addr, input int len, input logic id,
                             input int rm, input int am, input int hd);
    int t;
    logic [13:0] w;
    beat_t b;
    rmode = rm; amode = am; hold = hd;
    issued = 0; returned = 0; cur_id = id;
    for (int i = 0; i <= len; i++) begin
      w = 14'((addr >> 2) + i);
      exp_a.push_back(w);
      b.d = rd_word(w); b.id = id; b.last = (i == len);
      exp_b.push_back(b);
    end
    t = 0;
    @(negedge clk);
    while (!s_axi_arready && t < 200) begin @(negedge clk); t++; end
    chk("arready_wait", s_axi_arready, 1);
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arid = id; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("arvalid_next_cycle", m_al_arvalid, 1);
    chk("araddr_next_cycle", m_al_araddr, 14'(addr >> 2));
  endtask

  task automatic finish_burst(input logic [13:0] ef, input logic [13:0] el, input int len);
    int t = 0;
    while (returned < len + 1 && t < 3000) begin @(negedge clk); t++; end
    chk("beats", returned, len + 1);
    chk("first_word", first_a, ef);
    chk("last_word", last_a, el);
    @(negedge clk);
    @(negedge clk);
    chk("model_drained", exp_a.size() + exp_b.size(), 0);
    exp_a.delete(); exp_b.delete();
  endtask

  vec_t vecs [5];

  initial begin
    logic [15:0] ra;
    int rl;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[4] = 32'h12345678;

    vecs[0] = '{16'h0010, 0,  1'b0, 0, 0, 0, 14'h0004, 14'h0004};
    vecs[1] = '{16'h0020, 3,  1'b1, 0, 0, 0, 14'h0008, 14'h000b};
    vecs[2] = '{16'hfff8, 3,  1'b0, 0, 0, 0, 14'h3ffe, 14'h0001};
    vecs[3] = '{16'h03f8, 3,  1'b1, 1, 0, 0, 14'h00fe, 14'h0101};
    vecs[4] = '{16'h1004, 15, 1'b1, 2, 1, 3, 14'h0401, 14'h0410};

    rst = 1'b1;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arid = 1'b0; s_axi_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", s_axi_arready, 1);
    chk("rst_arvalid", m_al_arvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_araddr", m_al_araddr, 0);
    chk("rst_arid", m_al_arid, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      start_burst(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].rmode, vecs[v].amode, vecs[v].hold);
      finish_burst(vecs[v].exp_first, vecs[v].exp_last, vecs[v].len);
      if (vecs[v].rmode == 0 && vecs[v].amode == 0 && vecs[v].hold == 0)
        chk("consecutive_issue", last_c - first_c, vecs[v].len);
    end

    // Credit limit: returns withheld, only MAXO reads may be outstanding.
    start_burst(16'h0200, 7, 1'b0, 0, 0, 14);
    repeat (10) @(negedge clk);
    chk("credit_issued", issued, MAXO);
    chk("credit_arvalid_low", m_al_arvalid, 0);
    finish_burst(14'h0080, 14'h0087, 7);

    for (int r = 0; r < 20; r++) begin
      ra = 16'($urandom);
      rl = int'($urandom_range(0, 12));
      start_burst(ra, rl, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      finish_burst(14'(ra >> 2), 14'((ra >> 2) + rl), rl);
    end

    // Reset mid-burst after two issued reads, then a clean single beat.
    start_burst(16'h0100, 5, 1'b1, 0, 0, 60);
    repeat (4) @(negedge clk);
    chk("pre_reset_issued", issued, 2);
    rst = 1'b1;
    #1;
    chk("midrst_arready", s_axi_arready, 1);
    chk("midrst_arvalid", m_al_arvalid, 0);
    chk("midrst_araddr", m_al_araddr, 0);
    chk("midrst_arid", m_al_arid, 0);
    chk("midrst_rlast", s_axi_rlast, 0);
    chk("midrst_rvalid", s_axi_rvalid, 0);
    exp_a.delete(); exp_b.delete(); rq.delete();
    hold = 0; arr_chk = 0; st_r = 0; st_a = 0;
    @(negedge clk);
    rst = 1'b0;
    start_burst(16'h0010, 0, 1'b1, 0, 0, 0);
    finish_burst(14'h0004, 14'h0004, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
